// File: rtl/sha256_msg_schedule_if.sv
// Block handshake and round-stream bundle between the message scheduler and its neighbours.
interface sha256_msg_schedule_if;
    logic [511:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic [31:0]  msg;
    logic [31:0]  k;
    logic         soc;
    logic         eoc;
    logic         busy;

    // Block source / round-stream consumer side
    modport master (
        output block_in, block_valid,
        input  block_ready, msg, k, soc, eoc, busy
    );

    // Message scheduler side
    modport slave (
        input  block_in, block_valid,
        output block_ready, msg, k, soc, eoc, busy
    );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message scheduler: takes one padded 512-bit block and streams W[t]/K[t]
// for 64 rounds, with soc on round 0 and eoc on the cycle after round 63.
module sha256_msg_schedule (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_msg_schedule_if.slave  bus
);

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned NUM_WORDS  = 16;
    localparam int unsigned NUM_ROUNDS = 64;
    localparam int unsigned T_W        = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_e;

    localparam logic [WORD_W-1:0] K_ROM [NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [T_W-1:0] T_LAST = T_W'(NUM_ROUNDS - 1);

    // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_e            state_q, state_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [WORD_W-1:0] win_q [NUM_WORDS];
    logic [WORD_W-1:0] win_d [NUM_WORDS];
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] msg_q, msg_d;
    logic [WORD_W-1:0] k_q, k_d;
    logic              soc_q, soc_d;
    logic              eoc_q, eoc_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;

    // Next state, window shift/expansion, and next-cycle output values
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        w_new   = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

        case (state_q)
            S_IDLE: begin
                if (bus.block_valid) begin
                    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                        win_d[i] = bus.block_in[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
                    end
                    t_d     = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                for (int unsigned i = 0; i < NUM_WORDS - 1; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[NUM_WORDS-1] = w_new;
                if (t_q == T_LAST) begin
                    state_d = S_FINAL;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_FINAL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state will present
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        msg_d   = (state_d == S_ROUND) ? win_d[0]   : '0;
        k_d     = (state_d == S_ROUND) ? K_ROM[t_d] : '0;
        soc_d   = (state_d == S_ROUND) && (t_d == '0);
        eoc_d   = (state_d == S_FINAL);
    end

    // State, window and output registers; reset aborts any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            win_q   <= '{default: '0};
            msg_q   <= '0;
            k_q     <= '0;
            soc_q   <= 1'b0;
            eoc_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
            msg_q   <= msg_d;
            k_q     <= k_d;
            soc_q   <= soc_d;
            eoc_q   <= eoc_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bus.block_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.msg         = msg_q;
    assign bus.k           = k_q;
    assign bus.soc         = soc_q;
    assign bus.eoc         = eoc_q;

endmodule
